// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared constants, FSM state type and sizing helper for nibble_serial_adder
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble adder still needs a 1-bit counter.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is expanded directly from generate/propagate terms and cin.
    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial WIDTH-bit adder; OVF_FLAG_EN adds the ovf output
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_width(NIB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]             idx;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          sum_r;
    logic                      carry;
    logic [NIBBLE_W-1:0]       slice_s;
    logic                      slice_cout;
    logic [WIDTH+NIBBLE_W-1:0] sum_cat;
    logic                      accept;
    logic                      last_nib;

    assign accept   = (state == IDLE) && in_valid;
    assign last_nib = (state == ADD) && (idx == LAST_IDX);
    assign sum_cat  = {slice_s, sum_r};
    assign sum      = sum_r;
    assign cout     = carry;

`ifdef OVF_FLAG_EN
    logic slice_c3;

    cla4_slice u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .c3   (slice_c3),
        .cout (slice_cout)
    );

    // Carry into the MSB differs from carry out of it exactly on signed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last_nib) begin
            ovf <= slice_c3 ^ slice_cout;
        end
    end
`else
    cla4_slice u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .c3   (),
        .cout (slice_cout)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands shift down one nibble per ADD cycle while slice sums enter at the top,
    // so after NIB shifts nibble 0 of the result has arrived in bits [3:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
        end else if (state == ADD) begin
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            sum_r <= sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
            carry <= slice_cout;
            if (!last_nib) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
